// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and types for the decode-side register file and its write scoreboard.
package regfile_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue, operand-read and write-back signals between decode/write-back and the register file.
interface regfile_scoreboard_if;
  import regfile_pkg::*;

  logic     issue_valid;
  logic     rd_en_a;
  reg_idx_t rd_addr_a;
  logic     rd_en_b;
  reg_idx_t rd_addr_b;
  logic     issue_wr_en;
  reg_idx_t issue_dst;
  logic     stall;
  word_t    rd_data_a;
  word_t    rd_data_b;
  logic     wb_en;
  reg_idx_t wb_reg;
  word_t    wb_data;
  logic     flush;
  logic     wb_orphan_err;

  modport master (
    output issue_valid, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output issue_wr_en, issue_dst, wb_en, wb_reg, wb_data, flush,
    input  stall, rd_data_a, rd_data_b, wb_orphan_err
  );

  modport slave (
    input  issue_valid, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  issue_wr_en, issue_dst, wb_en, wb_reg, wb_data, flush,
    output stall, rd_data_a, rd_data_b, wb_orphan_err
  );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
module sb_counter
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic is_max,
  output logic is_zero
);

  cnt_t cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; saturation guards keep the count from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_max  = (cnt_q == CNT_MAX);
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// 8x32 register file with write-back bypass and a per-register in-flight write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  regfile_scoreboard_if.slave bus
);

  cnt_t                cnt      [NUM_REGS];
  word_t               regs_rd  [NUM_REGS];
  logic [NUM_REGS-1:0] cnt_max;
  logic [NUM_REGS-1:0] cnt_zero;
  logic [NUM_REGS-1:0] pend;

  logic  stall;
  logic  accept;
  word_t rd_data_a_q, rd_data_a_d;
  word_t rd_data_b_q, rd_data_b_d;
  logic  orphan_q, orphan_d;

  // R0 is constant zero and never tracked.
  assign cnt[0]      = '0;
  assign regs_rd[0]  = '0;
  assign cnt_max[0]  = 1'b0;
  assign cnt_zero[0] = 1'b1;
  assign pend[0]     = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic  wb_hit;
      logic  inc;
      logic  dec;
      word_t data_q, data_d;

      assign wb_hit = bus.wb_en && (bus.wb_reg == reg_idx_t'(gi));
      assign inc    = accept && bus.issue_wr_en && (bus.issue_dst == reg_idx_t'(gi));
      assign dec    = wb_hit && !cnt_zero[gi];

      sb_counter u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.flush),
        .inc     (inc),
        .dec     (dec),
        .cnt     (cnt[gi]),
        .is_max  (cnt_max[gi]),
        .is_zero (cnt_zero[gi])
      );

      // A register whose only outstanding write retires this cycle is readable via bypass.
      assign pend[gi] = !cnt_zero[gi] && !(wb_hit && (cnt[gi] == cnt_t'(1)));

      always_comb begin
        data_d = data_q;
        if (wb_hit) begin
          data_d = bus.wb_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign regs_rd[gi] = data_q;
    end
  endgenerate

  function automatic word_t operand(
    input logic     en,
    input reg_idx_t addr,
    input logic     wb_en,
    input reg_idx_t wb_reg,
    input word_t    wb_data,
    input word_t    stored
  );
    word_t val;
    val = '0;
    if (en && (addr != '0)) begin
      val = (wb_en && (wb_reg == addr)) ? wb_data : stored;
    end
    return val;
  endfunction

  always_comb begin
    logic hz_a;
    logic hz_b;
    logic hz_waw;
    hz_a   = bus.rd_en_a && pend[bus.rd_addr_a];
    hz_b   = bus.rd_en_b && pend[bus.rd_addr_b];
    hz_waw = bus.issue_wr_en && (bus.issue_dst != '0) && cnt_max[bus.issue_dst];
    stall  = bus.issue_valid && !bus.flush && (hz_a || hz_b || hz_waw);
    accept = bus.issue_valid && !stall && !bus.flush;
  end

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (accept) begin
      rd_data_a_d = operand(bus.rd_en_a, bus.rd_addr_a, bus.wb_en, bus.wb_reg,
                            bus.wb_data, regs_rd[bus.rd_addr_a]);
      rd_data_b_d = operand(bus.rd_en_b, bus.rd_addr_b, bus.wb_en, bus.wb_reg,
                            bus.wb_data, regs_rd[bus.rd_addr_b]);
    end
  end

  // A write-back with nothing in flight points at a tracking bug upstream; latch it.
  always_comb begin
    orphan_d = orphan_q;
    if (bus.wb_en && (bus.wb_reg != '0) && cnt_zero[bus.wb_reg] && !bus.flush) begin
      orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      orphan_q    <= 1'b0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      orphan_q    <= orphan_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.rd_data_a     = rd_data_a_q;
  assign bus.rd_data_b     = rd_data_b_q;
  assign bus.wb_orphan_err = orphan_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven check of the register file scoreboard, bypass and orphan flag.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ea;
    logic [2:0]  aa;
    logic        eb;
    logic [2:0]  ab;
    logic        we;
    logic [2:0]  dst;
    logic        wbe;
    logic [2:0]  wbr;
    logic [31:0] wbd;
    logic        fl;
    logic        exp_stall;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(
    input logic iv, input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab,
    input logic we, input logic [2:0] dst, input logic wbe, input logic [2:0] wbr,
    input logic [31:0] wbd, input logic fl,
    input logic s, input logic [31:0] a, input logic [31:0] b, input logic e
  );
    vec_t v;
    v.iv = iv; v.ea = ea; v.aa = aa; v.eb = eb; v.ab = ab;
    v.we = we; v.dst = dst; v.wbe = wbe; v.wbr = wbr; v.wbd = wbd; v.fl = fl;
    v.exp_stall = s; v.exp_a = a; v.exp_b = b; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.rd_en_a = 1'b0; bus.rd_addr_a = '0;
    bus.rd_en_b = 1'b0; bus.rd_addr_b = '0; bus.issue_wr_en = 1'b0; bus.issue_dst = '0;
    bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0; bus.flush = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    bus.issue_valid = v.iv; bus.rd_en_a = v.ea; bus.rd_addr_a = v.aa;
    bus.rd_en_b = v.eb; bus.rd_addr_b = v.ab; bus.issue_wr_en = v.we; bus.issue_dst = v.dst;
    bus.wb_en = v.wbe; bus.wb_reg = v.wbr; bus.wb_data = v.wbd; bus.flush = v.fl;
    #2;
    check({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, v.exp_stall});
    @(posedge clk);
    #1;
    check({tag, ".rd_data_a"}, bus.rd_data_a, v.exp_a);
    check({tag, ".rd_data_b"}, bus.rd_data_b, v.exp_b);
    check({tag, ".orphan"}, {31'd0, bus.wb_orphan_err}, {31'd0, v.exp_err});
    $display("%s: stall=%0b rd_data_a=%h rd_data_b=%h orphan=%0b",
             tag, bus.stall, bus.rd_data_a, bus.rd_data_b, bus.wb_orphan_err);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            iv ea aa eb ab we dst wbe wbr wbd           fl  stall a             b             err
    vecs[0]  = mk(1, 1, 3, 1, 5, 1, 2, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        0);
    vecs[1]  = mk(1, 1, 2, 0, 0, 0, 0, 1, 2, 32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 32'h0,        0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        0);
    vecs[3]  = mk(1, 1, 4, 1, 2, 0, 0, 0, 0, 32'h0,        0,  1, 32'h0,        32'h0,        0);
    vecs[4]  = mk(1, 1, 4, 1, 2, 0, 0, 1, 4, 32'h12,       0,  0, 32'h12,       32'hDEADBEEF, 0);
    vecs[5]  = mk(1, 1, 4, 0, 0, 1, 6, 0, 0, 32'h0,        0,  0, 32'h12,       32'h0,        0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        0);
    vecs[8]  = mk(1, 1, 4, 0, 0, 1, 6, 0, 0, 32'h0,        0,  1, 32'h0,        32'h0,        0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66,       0,  0, 32'h0,        32'h0,        0);
    vecs[10] = mk(1, 1, 4, 0, 0, 1, 6, 0, 0, 32'h0,        0,  0, 32'h12,       32'h0,        0);
    vecs[11] = mk(1, 1, 5, 0, 0, 1, 5, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        0);
    vecs[12] = mk(1, 1, 0, 1, 4, 1, 0, 1, 0, 32'hFFFFFFFF, 0,  0, 32'h0,        32'h12,       0);
    vecs[13] = mk(1, 1, 0, 1, 3, 0, 0, 1, 0, 32'hFFFFFFFF, 0,  0, 32'h0,        32'h0,        0);
    vecs[14] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        0);
    vecs[15] = mk(1, 1, 1, 1, 6, 0, 0, 0, 0, 32'h0,        1,  0, 32'h0,        32'h0,        0);
    vecs[16] = mk(1, 1, 1, 1, 6, 0, 0, 0, 0, 32'h0,        0,  0, 32'h0,        32'h66,       0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11,       0,  0, 32'h0,        32'h66,       1);
    vecs[18] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0,  0, 32'h11,       32'h0,        1);

    drive_idle();
    rst_n = 1'b0;
    #12;
    check("reset.rd_data_a", bus.rd_data_a, 32'h0);
    check("reset.rd_data_b", bus.rd_data_b, 32'h0);
    check("reset.orphan", {31'd0, bus.wb_orphan_err}, 32'h0);
    check("reset.stall", {31'd0, bus.stall}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Same-cycle issue and retire on R2 must leave one write outstanding.
    apply("h0", mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'h0,  1));
    apply("h1", mk(1, 0, 0, 0, 0, 1, 2, 1, 2, 32'hAB, 0, 0, 32'h0,  32'h0,  1));
    apply("h2", mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h0,  1));
    apply("h3", mk(1, 1, 2, 0, 0, 0, 0, 1, 2, 32'hCD, 0, 0, 32'hCD, 32'h0,  1));
    apply("h4", mk(1, 1, 2, 1, 2, 0, 0, 0, 0, 32'h0,  0, 0, 32'hCD, 32'hCD, 1));
    apply("h5", mk(1, 1, 2, 0, 0, 1, 3, 0, 0, 32'h0,  0, 0, 32'hCD, 32'h0,  1));

    // Asynchronous reset mid-cycle clears outputs, registers and counters at once.
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.rd_data_a", bus.rd_data_a, 32'h0);
    check("midreset.orphan", {31'd0, bus.wb_orphan_err}, 32'h0);
    $display("midreset: rd_data_a=%h orphan=%0b", bus.rd_data_a, bus.wb_orphan_err);
    rst_n = 1'b1;
    apply("h6", mk(1, 1, 3, 1, 4, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
